// File: rtl/xc_fifo_wr_skid.sv
// Write-side adapter: valid/ready stream into a sync FIFO core through a 2-entry skid buffer.
// Upstream ready is registered, so there is no combinational path from core full to s_ready_o.
module xc_fifo_wr_skid #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned LOG2_DEPTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  s_valid_i,
    input  logic [WIDTH-1:0]      s_data_i,
    output logic                  s_ready_o,
    output logic [1:0]            skid_cnt_o,
    input  logic                  rd_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  ne_o,
    output logic                  full_o,
    input  logic [LOG2_DEPTH-1:0] af_count_i,
    input  logic [LOG2_DEPTH-1:0] ae_count_i,
    output logic                  af_o,
    output logic                  ae_o
);

    localparam int unsigned CW = LOG2_DEPTH + 1;

    // Encoding doubles as the skid occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } skid_state_e;

    skid_state_e          state_q, state_d;
    logic [WIDTH-1:0]     slot0_q, slot1_q;
    logic                 s_ready_q;
    logic                 accept, drain, core_full, rd_en;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wptr_q, rptr_q;
    logic [CW-1:0]        count_q;
    logic [WIDTH-1:0]     data_q;

    function automatic logic [LOG2_DEPTH-1:0] ptr_inc(input logic [LOG2_DEPTH-1:0] p);
        return (p == LOG2_DEPTH'(DEPTH - 1)) ? '0 : p + LOG2_DEPTH'(1);
    endfunction

    assign core_full = (count_q == CW'(DEPTH));
    assign accept    = s_valid_i & s_ready_q;
    assign drain     = (state_q != StEmpty) & ~core_full;
    assign rd_en     = rd_i & (count_q != '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StOne;
            StOne: begin
                if (accept && !drain)      state_d = StTwo;
                else if (drain && !accept) state_d = StEmpty;
            end
            StTwo:   if (drain) state_d = StOne;
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StEmpty;
            slot0_q   <= '0;
            slot1_q   <= '0;
            s_ready_q <= 1'b0;
        end else if (clr_i) begin
            state_q   <= StEmpty;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= (state_d != StTwo);
            case (state_q)
                StEmpty: if (accept) slot0_q <= s_data_i;
                StOne: begin
                    // With a simultaneous drain slot0 is leaving, so the new word replaces it.
                    if (accept && drain) slot0_q <= s_data_i;
                    else if (accept)     slot1_q <= s_data_i;
                end
                StTwo:   if (drain) slot0_q <= slot1_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (drain && !clr_i) mem[wptr_q] <= slot0_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else if (clr_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (drain) wptr_q <= ptr_inc(wptr_q);
            if (rd_en) begin
                rptr_q <= ptr_inc(rptr_q);
                data_q <= mem[rptr_q];
            end
            case ({drain, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

    assign s_ready_o  = s_ready_q;
    assign skid_cnt_o = state_q;
    assign data_o     = data_q;
    assign ne_o       = (count_q != '0);
    assign full_o     = core_full;
    assign af_o       = (count_q >= (CW'(DEPTH) - {1'b0, af_count_i}));
    assign ae_o       = (count_q <= {1'b0, ae_count_i});

endmodule

// File: tb/tb_xc_fifo_wr_skid.sv
// Bench for xc_fifo_wr_skid: table-driven fill/release, hand sequences for clear and
// throughput, then random traffic against a queue-based reference model.
module tb_xc_fifo_wr_skid;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst, clr, s_valid, rd;
    logic [31:0] s_data, data_o;
    logic        s_ready, ne, full, af, ae;
    logic [1:0]  skid_cnt;
    logic [2:0]  af_cnt, ae_cnt;

    always #5 clk = ~clk;

    xc_fifo_wr_skid #(.WIDTH(32), .DEPTH(D), .LOG2_DEPTH(3)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (clr),
        .s_valid_i  (s_valid),
        .s_data_i   (s_data),
        .s_ready_o  (s_ready),
        .skid_cnt_o (skid_cnt),
        .rd_i       (rd),
        .data_o     (data_o),
        .ne_o       (ne),
        .full_o     (full),
        .af_count_i (af_cnt),
        .ae_count_i (ae_cnt),
        .af_o       (af),
        .ae_o       (ae)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: words waiting in the skid buffer and words held in the core.
    logic [31:0] skid_q[$];
    logic [31:0] core_q[$];
    logic        m_ready;
    logic [31:0] m_dout;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic [1:0]  skid;
        logic        rdy;
        logic        ne;
        logic        full;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        skid_q.delete();
        core_q.delete();
        m_ready = 1'b0;
        m_dout  = '0;
    endtask

    task automatic model_edge(input logic v, input logic [31:0] d, input logic r, input logic c);
        bit acc, drn;
        if (c) begin
            skid_q.delete();
            core_q.delete();
            m_ready = 1'b0;
        end else begin
            acc = v && m_ready;
            drn = (skid_q.size() > 0) && (core_q.size() < D);
            if (r && core_q.size() > 0) m_dout = core_q.pop_front();
            if (drn) core_q.push_back(skid_q.pop_front());
            if (acc) skid_q.push_back(d);
            m_ready = (skid_q.size() < 2);
        end
    endtask

    task automatic check_model();
        chk("s_ready", 32'(s_ready), 32'(m_ready));
        chk("skid_cnt", 32'(skid_cnt), 32'(skid_q.size()));
        chk("ne", 32'(ne), 32'(core_q.size() > 0));
        chk("full", 32'(full), 32'(core_q.size() == D));
        chk("af", 32'(af), 32'(core_q.size() >= D - int'(af_cnt)));
        chk("ae", 32'(ae), 32'(core_q.size() <= int'(ae_cnt)));
        chk("data_o", data_o, m_dout);
    endtask

    task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic c);
        s_valid = v;
        s_data  = d;
        rd      = r;
        clr     = c;
        model_edge(v, d, r, c);
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        int first_acc, last_acc, n_acc, first_full;

        rst = 1'b1; clr = 1'b0; s_valid = 1'b0; s_data = '0; rd = 1'b0;
        af_cnt = 3'd2; ae_cnt = 3'd1;
        model_reset();

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_skid", 32'(skid_cnt), 32'd0);
        chk("rst_ne", 32'(ne), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready0", 32'(s_ready), 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("post_rst_ready1", 32'(s_ready), 32'd1);

        // Fill and release, hand-derived expectations
        tbl[0] = '{1'b1, 32'h01, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0};
        for (int k = 1; k < 8; k++) tbl[k] = '{1'b1, 32'(k + 1), 1'b0, 2'd1, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 32'h09, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 32'h0A, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 32'h0B, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 32'h0B, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 32'h0B, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 32'h0B, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
            chk($sformatf("tbl%0d_skid", i), 32'(skid_cnt), 32'(tbl[i].skid));
            chk($sformatf("tbl%0d_ready", i), 32'(s_ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_ne", i), 32'(ne), 32'(tbl[i].ne));
            chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].full));
            if (i == 11) chk("first_read", data_o, 32'h01);
        end
        for (int i = 2; i <= 11; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            chk($sformatf("drain_word%0d", i), data_o, 32'(i));
        end
        chk("drained_ne", 32'(ne), 32'd0);

        // Clear from the full-plus-skid state
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
        chk("preclr_skid", 32'(skid_cnt), 32'd2);
        cycle(1'b1, 32'hCC, 1'b0, 1'b1);
        chk("clr_skid", 32'(skid_cnt), 32'd0);
        chk("clr_ne", 32'(ne), 32'd0);
        chk("clr_full", 32'(full), 32'd0);
        chk("clr_ready", 32'(s_ready), 32'd0);
        cycle(1'b1, 32'hDD, 1'b0, 1'b0);
        chk("postclr_ready", 32'(s_ready), 32'd1);
        chk("postclr_skid", 32'(skid_cnt), 32'd0);
        cycle(1'b1, 32'hDD, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("postclr_word", data_o, 32'hDD);

        // Throughput: 10 back-to-back accepts, core full after 8 consecutive writes
        first_acc = -1; last_acc = -1; n_acc = 0; first_full = -1;
        for (int i = 0; i < 12; i++) begin
            if (s_ready) begin
                if (first_acc < 0) first_acc = i;
                last_acc = i;
                n_acc++;
            end
            cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
            if (full && first_full < 0) first_full = i;
        end
        chk("tput_accepts", 32'(n_acc), 32'd10);
        chk("tput_first", 32'(first_acc), 32'd0);
        chk("tput_span", 32'(last_acc - first_acc + 1), 32'd10);
        chk("tput_full_edge", 32'(first_full), 32'd8);
        repeat (12) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("tput_last_word", data_o, 32'h109);

        // Random traffic
        af_cnt = 3'($urandom_range(0, 7));
        ae_cnt = 3'($urandom_range(0, 7));
        for (int i = 0; i < 20000; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 999) == 0));
            chk("skid_le2", 32'(skid_cnt <= 2'd2), 32'd1);
        end
        repeat (14) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("final_empty", 32'(ne), 32'd0);
        chk("final_skid", 32'(skid_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
